// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core request/response and memory port bundle for mem_port_arbiter.
// Stats outputs exist only when ARB_STATS_EN is defined.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              c0_req_valid, c0_req_we, c0_req_ready;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_wdata;
  logic              c0_rsp_valid, c0_rsp_err;
  logic [DATA_W-1:0] c0_rsp_rdata;

  logic              c1_req_valid, c1_req_we, c1_req_ready;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_wdata;
  logic              c1_rsp_valid, c1_rsp_err;
  logic [DATA_W-1:0] c1_rsp_rdata;

  logic              mem_r_en, mem_w_en;
  logic [ADDR_W-1:0] mem_r_adrs, mem_w_adrs;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_r_valid, mem_w_valid;
  logic [DATA_W-1:0] mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] stat_grants0, stat_grants1, stat_conflicts;
  logic [7:0]  stat_timeouts;
`endif

  // Arbiter side
  modport slave (
    input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    input  mem_r_valid, mem_w_valid, mem_rdata,
    output c0_req_ready, c0_rsp_valid, c0_rsp_rdata, c0_rsp_err,
    output c1_req_ready, c1_rsp_valid, c1_rsp_rdata, c1_rsp_err,
    output mem_r_en, mem_w_en, mem_r_adrs, mem_w_adrs, mem_wdata
`ifdef ARB_STATS_EN
    , output stat_grants0, stat_grants1, stat_timeouts, stat_conflicts
`endif
  );

  // Cores + memory side
  modport master (
    output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
    output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
    output mem_r_valid, mem_w_valid, mem_rdata,
    input  c0_req_ready, c0_rsp_valid, c0_rsp_rdata, c0_rsp_err,
    input  c1_req_ready, c1_rsp_valid, c1_rsp_rdata, c1_rsp_err,
    input  mem_r_en, mem_w_en, mem_r_adrs, mem_w_adrs, mem_wdata
`ifdef ARB_STATS_EN
    , input stat_grants0, stat_grants1, stat_timeouts, stat_conflicts
`endif
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; rr names the core favoured on a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] grant_c
);
  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = rr ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory load/store port between two cores, one transaction at a time.
// Define ARB_STATS_EN to add saturating grant/timeout/conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        state_q, state_d;
  logic              rr_q, rr_d, owner_q, owner_d;
  mem_req_t          req_q, req_d, req0, req1;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ready_q, ready_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic              r_en_q, r_en_d, w_en_q, w_en_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d, rsp_data;
  logic [1:0]        grant_c;
  logic              hit, done, timeout;

  assign req0 = '{we: bus.c0_req_we, addr: bus.c0_req_addr, wdata: bus.c0_req_wdata};
  assign req1 = '{we: bus.c1_req_we, addr: bus.c1_req_addr, wdata: bus.c1_req_wdata};
  assign hit  = req_q.we ? bus.mem_w_valid : bus.mem_r_valid;

  rr_arbiter2 u_pick (
    .req     ({bus.c1_req_valid, bus.c0_req_valid}),
    .rr      (rr_q),
    .grant_c (grant_c)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    ready_d     = 2'b00;
    r_en_d      = 1'b0;
    w_en_d      = 1'b0;
    rsp_valid_d = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    err_d       = err_q;
    done        = 1'b0;
    timeout     = 1'b0;
    rsp_data    = '0;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          owner_d = grant_c[1];
          req_d   = grant_c[1] ? req1 : req0;
          ready_d = grant_c;
          r_en_d  = ~req_d.we;
          w_en_d  = req_d.we;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hit) done = 1'b1;
        else     state_d = WAIT;
      end
      WAIT: begin
        if (hit) begin
          done = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          done    = 1'b1;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response is captured on the way into RESP so it appears registered there
    if (done) begin
      state_d              = RESP;
      rsp_valid_d[owner_q] = 1'b1;
      err_d[owner_q]       = timeout;
      rsp_data             = (timeout || req_q.we) ? '0 : bus.mem_rdata;
      if (owner_q) rdata1_d = rsp_data;
      else         rdata0_d = rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      req_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 2'b00;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      r_en_q      <= r_en_d;
      w_en_q      <= w_en_d;
      rsp_valid_q <= rsp_valid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      err_q       <= err_d;
    end
  end

  assign bus.c0_req_ready = ready_q[0];
  assign bus.c1_req_ready = ready_q[1];
  assign bus.c0_rsp_valid = rsp_valid_q[0];
  assign bus.c1_rsp_valid = rsp_valid_q[1];
  assign bus.c0_rsp_err   = err_q[0];
  assign bus.c1_rsp_err   = err_q[1];
  assign bus.c0_rsp_rdata = rdata0_q;
  assign bus.c1_rsp_rdata = rdata1_q;
  assign bus.mem_r_en     = r_en_q;
  assign bus.mem_w_en     = w_en_q;
  assign bus.mem_r_adrs   = req_q.addr;
  assign bus.mem_w_adrs   = req_q.addr;
  assign bus.mem_wdata    = req_q.wdata;

`ifdef ARB_STATS_EN
  logic [15:0] grants0_q, grants1_q, conflicts_q;
  logic [7:0]  timeouts_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q   <= '0;
      grants1_q   <= '0;
      conflicts_q <= '0;
      timeouts_q  <= '0;
    end else begin
      if (rsp_valid_q[0] && grants0_q != 16'hFFFF) grants0_q <= grants0_q + 16'd1;
      if (rsp_valid_q[1] && grants1_q != 16'hFFFF) grants1_q <= grants1_q + 16'd1;
      if (|(rsp_valid_q & err_q) && timeouts_q != 8'hFF) timeouts_q <= timeouts_q + 8'd1;
      if (state_q == IDLE && bus.c0_req_valid && bus.c1_req_valid && conflicts_q != 16'hFFFF)
        conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign bus.stat_grants0   = grants0_q;
  assign bus.stat_grants1   = grants1_q;
  assign bus.stat_timeouts  = timeouts_q;
  assign bus.stat_conflicts = conflicts_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single load/store data port of the shared `memory` block between two core paths (core 0, core 1).
- Accepts one load or store request at a time from either core and issues it to memory. It then waits for memory's valid, returns the response to the owning core, and rotates priority round-robin.
- Sits in the `sys_clk` domain. Per-core synchronizers stay outside this block.

Parameters:
- ADDR_W, 11, memory word address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 16, max cycles in WAIT before the transaction is aborted with an error

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cN_req_valid  in  1  core N (N=0,1) request pending; held until cN_req_ready
- cN_req_we  in  1  1=store, 0=load
- cN_req_addr  in  ADDR_W  load/store address
- cN_req_wdata  in  DATA_W  store data
- cN_req_ready  out  1  one-cycle pulse: request of core N accepted
- cN_rsp_valid  out  1  one-cycle pulse: response for core N
- cN_rsp_rdata  out  DATA_W  load data (0 for stores); valid with cN_rsp_valid
- cN_rsp_err  out  1  timeout abort; valid with cN_rsp_valid
- mem_r_en  out  1  memory read enable (to memory r_en2)
- mem_w_en  out  1  memory write enable (to memory w_en)
- mem_r_adrs  out  ADDR_W  read address
- mem_w_adrs  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- mem_r_valid  in  1  memory read valid
- mem_w_valid  in  1  memory write valid
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; round-robin pointer rr=0 (core 0 favoured).
  - All outputs are 0, including the address and data registers.
  - Any in-flight transaction is dropped silently; no response is issued.
- State IDLE:
  - If neither request is valid, stay in IDLE.
  - If exactly one request is valid, grant that core.
  - If both are valid, grant core rr.
  - On a grant: latch owner, we, addr, wdata; go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - cOWNER_req_ready=1.
  - mem_r_en=~we, mem_w_en=we.
  - mem_r_adrs / mem_w_adrs = latched addr; mem_wdata = latched wdata.
  - Go to WAIT. A matching valid already present in this cycle is also accepted: capture it and go directly to RESP.
- State WAIT:
  - Enables are low.
  - On the matching valid (mem_r_valid for a load, mem_w_valid for a store): capture mem_rdata (loads) or 0 (stores); go to RESP.
  - A non-matching valid is ignored.
  - A wait counter starts at 0 on entry. When it reaches TIMEOUT_CYC-1 with no valid: set err=1, rdata=0, go to RESP.
- State RESP (1 cycle):
  - cOWNER_rsp_valid=1, with rsp_rdata and rsp_err driven.
  - rr = ~owner.
  - Go to IDLE.
- Latency with 1-cycle memory: req_valid sampled in cycle 0; ready and enable in cycle 1; mem valid in cycle 2; rsp_valid in cycle 3. Next grant is possible in cycle 4, so throughput is 1 transaction per 4 cycles.
- A non-owner core holding req_valid waits; it is never dropped. Starvation bound is one transaction.
- Requests are not re-sampled after IDLE. Changing cN_req_* before ready is a protocol violation with undefined result.
- At most one mem_r_en/mem_w_en pulse per transaction; both are never high together.
- cN_rsp_rdata holds its last value between responses. Only rsp_valid is a pulse.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds outputs:
  - stat_grants0 (16 bits): saturating count of RESP cycles for core 0.
  - stat_grants1 (16 bits): same for core 1.
  - stat_timeouts (8 bits): saturating count of err responses.
  - stat_conflicts (16 bits): saturating count of IDLE cycles where both requests are valid.
- All stat outputs clear on reset.
- When not defined, these ports and registers do not exist and the behaviour of all other ports is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP}
  - typedef struct mem_req_t {we, addr, wdata}
  - localparam defaults for ADDR_W / DATA_W.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick (inputs: req[1:0], rr; outputs: grant one-hot).
- FSM, datapath latch, timeout counter and stats stay in mem_port_arbiter.

Test Plan:
- Single load: c0 load addr 0x010, memory returns 0xDEADBEEF with 1-cycle latency -> c0_req_ready in cycle 1, mem_r_en=1 with mem_r_adrs=0x010 in cycle 1, c0_rsp_valid with rdata 0xDEADBEEF and err=0 in cycle 3; c1 outputs stay 0.
- Simultaneous requests from reset: c0 store 0x005←0x1234 and c1 load 0x006, both held -> c0 served first (rr=0), mem_w_en with w_adrs 0x005 / wdata 0x1234; c1 issued in cycle 5, c1_rsp_valid in cycle 7.
- Continuous contention: both cores hold valid for 20 transactions -> grants strictly alternate 0,1,0,1…; no core receives two consecutive grants.
- Timeout: c1 load, memory never asserts valid -> c1_rsp_valid with err=1 and rdata=0 exactly TIMEOUT_CYC cycles after leaving ISSUE; the next request completes normally.
- Reset mid-WAIT: assert reset for 1 cycle while c0 load is in WAIT, then return mem_r_valid -> no c0_rsp_valid; state is IDLE, all outputs 0, rr=0.
- With ARB_STATS_EN: 3 c0, 2 c1 and 1 timed-out transaction -> stat_grants0=3, stat_grants1=3, stat_timeouts=1; forcing 70000 grants saturates stat_grants0 at 0xFFFF.
